// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU memory initiator.
package lsu_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned BE_W  = XLEN / 8;
    localparam int unsigned OFF_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        WB   = 2'd3
    } lsu_state_e;

    // RISC-V funct3 encodings for loads and stores
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    // Captured bus request payload
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [BE_W-1:0] wmask;
    } mem_req_t;

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// EXU request, memory bus and WBU result signals of the LSU initiator.
interface lsu_mem_initiator_if;
    import lsu_pkg::*;

    logic            ex_valid;
    logic            ex_ready;
    logic            ex_ren;
    logic            ex_wen;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_addr;
    logic [XLEN-1:0] ex_wdata;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_we;
    logic [XLEN-1:0] mem_req_addr;
    logic [XLEN-1:0] mem_req_wdata;
    logic [BE_W-1:0] mem_req_wmask;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_rdata;

    logic            wb_valid;
    logic            wb_ready;
    logic [XLEN-1:0] wb_data;
    logic            wb_err;

    // LSU side
    modport master (
        input  ex_valid, ex_ren, ex_wen, ex_funct3, ex_addr, ex_wdata,
        output ex_ready,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output wb_valid, wb_data, wb_err,
        input  wb_ready
    );

    // EXU / memory / WBU side
    modport slave (
        output ex_valid, ex_ren, ex_wen, ex_funct3, ex_addr, ex_wdata,
        input  ex_ready,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  wb_valid, wb_data, wb_err,
        output wb_ready
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store shift/mask, load shift/extend, access legality.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [OFF_W-1:0] req_off_i,
    input  logic [2:0]       req_funct3_i,
    input  logic             req_store_i,
    input  logic [XLEN-1:0]  req_wdata_i,
    input  logic [OFF_W-1:0] rsp_off_i,
    input  logic [2:0]       rsp_funct3_i,
    input  logic [XLEN-1:0]  rsp_rdata_i,
    output logic [XLEN-1:0]  st_wdata_c_o,
    output logic [BE_W-1:0]  st_wmask_c_o,
    output logic             req_err_c_o,
    output logic [XLEN-1:0]  ld_data_c_o
);

    logic            misaligned;
    logic            illegal;
    logic [XLEN-1:0] sh;

    // Store data moves to its byte lane; mask follows access size
    always_comb begin
        st_wdata_c_o = req_wdata_i << {req_off_i, 3'b000};
        st_wmask_c_o = '0;
        case (req_funct3_i)
            SB:      st_wmask_c_o = BE_W'(8'h01) << req_off_i;
            SH:      st_wmask_c_o = BE_W'(8'h03) << req_off_i;
            SW:      st_wmask_c_o = BE_W'(8'h0F) << req_off_i;
            SD:      st_wmask_c_o = BE_W'(8'hFF);
            default: st_wmask_c_o = '0;
        endcase
    end

    // Size comes from funct3[1:0] for both loads and stores
    always_comb begin
        misaligned = 1'b0;
        case (req_funct3_i[1:0])
            2'b01:   misaligned = req_off_i[0];
            2'b10:   misaligned = |req_off_i[1:0];
            2'b11:   misaligned = |req_off_i;
            default: misaligned = 1'b0;
        endcase
        illegal     = req_store_i ? req_funct3_i[2] : (req_funct3_i == 3'b111);
        req_err_c_o = misaligned | illegal;
    end

    // Load data is shifted down from its lane, then sign/zero extended
    always_comb begin
        sh          = rsp_rdata_i >> {rsp_off_i, 3'b000};
        ld_data_c_o = '0;
        case (rsp_funct3_i)
            LB:      ld_data_c_o = {{(XLEN-8){sh[7]}},   sh[7:0]};
            LH:      ld_data_c_o = {{(XLEN-16){sh[15]}}, sh[15:0]};
            LW:      ld_data_c_o = {{(XLEN-32){sh[31]}}, sh[31:0]};
            LD:      ld_data_c_o = sh;
            LBU:     ld_data_c_o = XLEN'(sh[7:0]);
            LHU:     ld_data_c_o = XLEN'(sh[15:0]);
            LWU:     ld_data_c_o = XLEN'(sh[31:0]);
            default: ld_data_c_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator between EXU, data memory and WBU.
module lsu_mem_initiator
    import lsu_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    lsu_mem_initiator_if.master bus
);

    lsu_state_e       state_q, state_d;
    mem_req_t         req_q, req_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             store_q, store_d;
    logic             ex_ready_q, ex_ready_d;
    logic             req_valid_q, req_valid_d;
    logic             wb_valid_q, wb_valid_d;
    logic             wb_err_q, wb_err_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;

    logic [XLEN-1:0]  st_wdata_c;
    logic [BE_W-1:0]  st_wmask_c;
    logic             req_err_c;
    logic [XLEN-1:0]  ld_data_c;

    // Request side checks the incoming op; response side uses the captured op
    lsu_lane_align u_align (
        .req_off_i    (bus.ex_addr[OFF_W-1:0]),
        .req_funct3_i (bus.ex_funct3),
        .req_store_i  (bus.ex_wen),
        .req_wdata_i  (bus.ex_wdata),
        .rsp_off_i    (off_q),
        .rsp_funct3_i (funct3_q),
        .rsp_rdata_i  (bus.mem_rsp_rdata),
        .st_wdata_c_o (st_wdata_c),
        .st_wmask_c_o (st_wmask_c),
        .req_err_c_o  (req_err_c),
        .ld_data_c_o  (ld_data_c)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            off_q       <= '0;
            funct3_q    <= '0;
            store_q     <= 1'b0;
            ex_ready_q  <= 1'b1;
            req_valid_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_err_q    <= 1'b0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            store_q     <= store_d;
            ex_ready_q  <= ex_ready_d;
            req_valid_q <= req_valid_d;
            wb_valid_q  <= wb_valid_d;
            wb_err_q    <= wb_err_d;
            wb_data_q   <= wb_data_d;
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        store_d     = store_q;
        ex_ready_d  = ex_ready_q;
        req_valid_d = req_valid_q;
        wb_valid_d  = wb_valid_q;
        wb_err_d    = wb_err_q;
        wb_data_d   = wb_data_q;

        case (state_q)
            IDLE: begin
                if (bus.ex_valid) begin
                    off_d       = bus.ex_addr[OFF_W-1:0];
                    funct3_d    = bus.ex_funct3;
                    store_d     = bus.ex_wen;
                    req_d.we    = bus.ex_wen;
                    req_d.addr  = {bus.ex_addr[XLEN-1:OFF_W], OFF_W'(0)};
                    req_d.wdata = bus.ex_wen ? st_wdata_c : '0;
                    req_d.wmask = bus.ex_wen ? st_wmask_c : '0;
                    ex_ready_d  = 1'b0;
                    if (!bus.ex_ren && !bus.ex_wen) begin
                        state_d    = WB;
                        wb_valid_d = 1'b1;
                        wb_err_d   = 1'b0;
                        wb_data_d  = '0;
                    end else if (req_err_c) begin
                        state_d    = WB;
                        wb_valid_d = 1'b1;
                        wb_err_d   = 1'b1;
                        wb_data_d  = '0;
                    end else begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    state_d     = RSP;
                    req_valid_d = 1'b0;
                end
            end
            RSP: begin
                if (bus.mem_rsp_valid) begin
                    state_d    = WB;
                    wb_valid_d = 1'b1;
                    wb_err_d   = 1'b0;
                    wb_data_d  = store_q ? '0 : ld_data_c;
                end
            end
            WB: begin
                if (bus.wb_ready) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b0;
                    ex_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                ex_ready_d  = 1'b1;
                req_valid_d = 1'b0;
                wb_valid_d  = 1'b0;
            end
        endcase
    end

    assign bus.ex_ready      = ex_ready_q;
    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_we    = req_q.we;
    assign bus.mem_req_addr  = req_q.addr;
    assign bus.mem_req_wdata = req_q.wdata;
    assign bus.mem_req_wmask = req_q.wmask;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_data       = wb_data_q;
    assign bus.wb_err        = wb_err_q;

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Core-side load/store initiator; sits between EXU and the data-memory responder.
- Accepts one load/store per transaction from EXU and issues an 8-byte-aligned bus request with byte mask, lane-shifted write data and valid/ready handshake.
- Waits for the memory response, then aligns and sign- or zero-extends load data by funct3.
- Returns the result to WBU with a valid/ready handshake; one outstanding transaction at a time.

Parameters:
- XLEN, 64, data/address width.
- BE_W, XLEN/8, byte-mask width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EXU request valid
- ex_ready  out  1  LSU can accept a request
- ex_ren  in  1  load request
- ex_wen  in  1  store request
- ex_funct3  in  3  RISC-V funct3 size/sign code
- ex_addr  in  XLEN  byte address
- ex_wdata  in  XLEN  store data, LSB-justified
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = write
- mem_req_addr  out  XLEN  ex_addr with [2:0] forced to 0
- mem_req_wdata  out  XLEN  store data shifted to its byte lane
- mem_req_wmask  out  BE_W  byte enables; 0 for reads
- mem_rsp_valid  in  1  response valid (read data or write ack)
- mem_rsp_rdata  in  XLEN  aligned 64-bit read word
- wb_valid  out  1  result valid
- wb_ready  in  1  WBU accepts result
- wb_data  out  XLEN  extended load data; 0 for stores and errors
- wb_err  out  1  misaligned address or illegal funct3

Behaviour:
- Reset (async on rst_n low): state=IDLE; ex_ready=1; mem_req_valid=0; wb_valid=0; wb_err=0; wb_data=0; all captured request registers=0.
- Reset asserted mid-transaction aborts it. No response is later reported; a late mem_rsp_valid is ignored.
- States: IDLE, REQ, RSP, WB.
- IDLE: ex_ready=1. On ex_valid, capture addr, wdata, funct3, and op (store if ex_wen, else load if ex_ren; both set = store).
  - Neither ren nor wen set: go to WB with wb_data=0, wb_err=0.
  - Error detected: go to WB with wb_err=1, wb_data=0; no bus request is issued.
  - Otherwise go to REQ.
- Error conditions:
  - Load funct3 111, or store funct3 >= 100.
  - Misalignment: off=addr[2:0]; halfword needs off[0]==0, word needs off[1:0]==0, double needs off==0.
- REQ: mem_req_valid=1. Address, we, wdata and wmask are driven from registers and held stable until mem_req_ready. On handshake go to RSP.
- RSP: mem_req_valid=0. Wait for mem_rsp_valid (stores also wait for the ack); mem_rsp_valid in any other state is ignored. On response, a load registers the extended data; go to WB.
- WB: wb_valid=1; wb_data and wb_err held stable until wb_ready. On wb_ready go to IDLE. ex_ready=0 in all states except IDLE (no bypass).
- Store lane rules: mem_req_wdata = wdata << (8*off). mem_req_wmask by funct3:
  - 000: 0x01<<off
  - 001: 0x03<<off
  - 010: 0x0F<<off
  - 011: 0xFF
- Load rules: sh = mem_rsp_rdata >> (8*off), then extend by funct3:
  - 000 lb: sign-extend sh[7:0]
  - 001 lh: sign-extend sh[15:0]
  - 010 lw: sign-extend sh[31:0]
  - 011 ld: sh unchanged
  - 100 lbu, 101 lhu, 110 lwu: zero-extend the same widths
- Minimum latency with ready/rsp/wb_ready all asserted:
  - Cycle 0: accept.
  - Cycle 1: request handshake.
  - Cycle 2: earliest response (the responder must answer at least 1 cycle after the handshake).
  - Cycle 3: wb_valid.
  - Cycle 4: next accept.
- Error or no-op path: accept at cycle 0, wb_valid at cycle 1.

Decomposition:
- Shared package lsu_pkg holds:
  - state enum (IDLE/REQ/RSP/WB);
  - funct3 constants (LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD);
  - BE_W.
- One combinational sub-module, lsu_lane_align, computes the store shift and mask, the load shift and extend, and the misalign/illegal check. The top holds the FSM and registers.

Test Plan:
- sd 0x1122334455667788 @0x80008ff0, ready=1, ack 1 cycle later -> req_addr 0x80008ff0, wmask 0xFF, wb_valid cycle 3, wb_data 0, err 0.
- sb 0xAB @0x80000005 -> wmask 0x20, wdata 0x0000AB0000000000, addr 0x80000000.
- lb @0x80000003, rdata 0x00000000_80000000 -> wb_data 0xFFFFFFFFFFFFFF80. lbu at the same address -> wb_data 0x80.
- lw @0x80000004, rdata 0x89ABCDEF_00000000 -> 0xFFFFFFFF89ABCDEF. lwu -> 0x0000000089ABCDEF.
- lh @0x80000001 -> no mem_req_valid, wb_valid on the next cycle, wb_err=1, wb_data=0. Also funct3 111 load -> err.
- Backpressure and reset:
  - Hold mem_req_ready=0 for 5 cycles: addr, wdata and mask stay stable.
  - Hold wb_ready=0 for 4 cycles: wb_data stays stable and ex_ready stays 0.
  - Assert rst_n=0 in RSP: outputs return to reset values; a later mem_rsp_valid produces no wb_valid.
